// File: rtl/sifh_hist_engine.sv
// sifh_hist_engine: pipelined +1 read-modify-write histogram builder with hazard forwarding, saturation and clear sweep
//   clk_i/res_ni             clock, async active-low reset
//   start_i/clear_req_i      begin frame / clear sweep (sampled in IDLE)
//   frame_len_i              events accepted per frame (sampled on start)
//   ts_valid_i/ts_bin_i/ts_pix_i  event strobe and {pixel,bin}
//   raddr_o/ren_o/rdata_i    RAM read port, rdata one cycle after the read edge
//   waddr_o/wdata_o/wen_o    RAM write port
//   busy_o/done_o/sat_flag_o status: busy, end pulse, sticky saturation
module sifh_hist_engine #(
  parameter int NB = 8,
  parameter int NPIX_W = 2,
  parameter int CW = 12,
  parameter int ACQ_W = 24
) (
  input  logic                 clk_i,
  input  logic                 res_ni,
  input  logic                 start_i,
  input  logic                 clear_req_i,
  input  logic [ACQ_W-1:0]     frame_len_i,
  input  logic                 ts_valid_i,
  input  logic [NB-1:0]        ts_bin_i,
  input  logic [NPIX_W-1:0]    ts_pix_i,
  output logic [NPIX_W+NB-1:0] raddr_o,
  output logic                 ren_o,
  input  logic [CW-1:0]        rdata_i,
  output logic [NPIX_W+NB-1:0] waddr_o,
  output logic [CW-1:0]        wdata_o,
  output logic                 wen_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_flag_o
);
  localparam int AW = NPIX_W + NB;
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [ACQ_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [AW-1:0] caddr_q, caddr_d, raddr_q, raddr_d, a2_q, waddr_q, waddr_d, fa_q;
  logic ren_q, v2_q, wen_q, wen_d, fv_q, busy_q, done_q, sat_q, sat_d;
  logic [CW-1:0] wdata_q, wdata_d, fd_q, base;
  logic accept, go, clr_go, clr;
  assign go = state_q == IDLE && start_i && !clear_req_i;
  assign clr_go = state_q == IDLE && clear_req_i;
  assign clr = state_q == CLEAR;
  // leaving ACCUM on count == frame_len keeps count < frame_len while in ACCUM
  assign accept = state_q == ACCUM && ts_valid_i;
  // newest in-flight value wins: write register (one behind), then the write
  // committing to RAM on the same edge the current read was sampled
  assign base = (wen_q && waddr_q == a2_q) ? wdata_q : (fv_q && fa_q == a2_q) ? fd_q : rdata_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (clear_req_i) state_d = CLEAR;
             else if (start_i) state_d = frame_len_i == '0 ? DRAIN : ACCUM;
      CLEAR: if (&caddr_q) state_d = DONE;
      ACCUM: if (cnt_d == len_q) state_d = DRAIN;
      DRAIN: if (!ren_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = go ? '0 : cnt_q + ACQ_W'(accept);
    len_d = go ? frame_len_i : len_q;
    caddr_d = clr ? caddr_q + 1'b1 : '0;
    raddr_d = accept ? {ts_pix_i, ts_bin_i} : raddr_q;
    wen_d = clr || v2_q;
    waddr_d = clr ? caddr_q : v2_q ? a2_q : waddr_q;
    wdata_d = clr ? '0 : v2_q ? (&base ? base : base + 1'b1) : wdata_q;
    sat_d = (go || clr_go) ? 1'b0 : sat_q | (v2_q && &base);
  end
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      caddr_q <= '0;
      raddr_q <= '0;
      ren_q <= 1'b0;
      a2_q <= '0;
      v2_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      fa_q <= '0;
      fd_q <= '0;
      fv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      caddr_q <= caddr_d;
      raddr_q <= raddr_d;
      ren_q <= accept;
      a2_q <= raddr_q;
      v2_q <= ren_q;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
      fa_q <= waddr_q;
      fd_q <= wdata_q;
      fv_q <= wen_q;
      busy_q <= state_d == CLEAR || state_d == ACCUM || state_d == DRAIN;
      done_q <= state_d == DONE;
      sat_q <= sat_d;
    end
  end
  assign raddr_o = raddr_q;
  assign ren_o = ren_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign wen_o = wen_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sat_flag_o = sat_q;
endmodule

// File: tb/tb_sifh_hist_engine.sv
// tb_sifh_hist_engine: scoreboard bench for sifh_hist_engine with a behavioural histogram RAM
module tb_sifh_hist_engine;
  localparam int NB = 8;
  localparam int NPIX_W = 2;
  localparam int CW = 12;
  localparam int ACQ_W = 24;
  localparam int AW = NB + NPIX_W;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic start = 1'b0;
  logic clear_req = 1'b0;
  logic ts_valid = 1'b0;
  logic [ACQ_W-1:0] frame_len = '0;
  logic [NB-1:0] ts_bin = '0;
  logic [NPIX_W-1:0] ts_pix = '0;
  logic [AW-1:0] raddr, waddr;
  logic ren, wen, busy, done, sat_flag;
  logic [CW-1:0] rdata, wdata;
  logic [CW-1:0] mem [1 << AW];
  logic pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [CW-1:0] pre_data = '0;
  int model [1 << AW];
  logic [AW+CW-1:0] sbq [$];
  logic [AW+CW-1:0] exp_w;
  int tests = 0;
  int fails = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int done_cnt = 0;

  sifh_hist_engine #(.NB(NB), .NPIX_W(NPIX_W), .CW(CW), .ACQ_W(ACQ_W)) dut (
    .clk_i(clk), .res_ni(res_n), .start_i(start), .clear_req_i(clear_req),
    .frame_len_i(frame_len), .ts_valid_i(ts_valid), .ts_bin_i(ts_bin), .ts_pix_i(ts_pix),
    .raddr_o(raddr), .ren_o(ren), .rdata_i(rdata), .waddr_o(waddr), .wdata_o(wdata),
    .wen_o(wen), .busy_o(busy), .done_o(done), .sat_flag_o(sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (ren) ren_cnt++;
    if (done) done_cnt++;
    if (wen) begin
      wen_cnt++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: unexpected write addr=%0d data=%0d", waddr, wdata);
      end else begin
        exp_w = sbq.pop_front();
        if ({waddr, wdata} !== exp_w) begin
          fails++;
          $display("FAIL scoreboard: got addr=%0d data=%0d, need addr=%0d data=%0d",
                   waddr, wdata, exp_w[AW+CW-1:CW], exp_w[CW-1:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int a);
    int v;
    v = model[a] < MAXC ? model[a] + 1 : model[a];
    model[a] = v;
    sbq.push_back({AW'(a), CW'(v)});
  endtask

  task automatic drive_ev(input int a, input bit expect_write);
    ts_valid = 1'b1;
    {ts_pix, ts_bin} = AW'(a);
    if (expect_write) push_ev(a);
    tick();
  endtask

  task automatic start_frame(input int len);
    frame_len = ACQ_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done || done_cnt > d0) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no done pulse within 60 cycles");
    end
  endtask

  task automatic test_reset;
    res_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({raddr, ren, waddr, wdata, wen, busy, done, sat_flag} !== '0) begin
      fails++;
      $display("FAIL reset: outputs=%h need 0", {raddr, ren, waddr, wdata, wen, busy, done, sat_flag});
    end
    res_n = 1'b1;
    tick();
  endtask

  task automatic test_clear;
    int bc, dc, r0;
    for (int i = 0; i < (1 << AW); i++) begin
      model[i] = 0;
      sbq.push_back({AW'(i), CW'(0)});
    end
    r0 = ren_cnt;
    clear_req = 1'b1;
    start = 1'b1;
    frame_len = ACQ_W'(5);
    tick();
    clear_req = 1'b0;
    start = 1'b0;
    bc = 0;
    dc = 0;
    for (int k = 0; k < 1100; k++) begin
      bc += int'(busy);
      dc += int'(done);
      tick();
    end
    tests++;
    if (bc != 1024) begin fails++; $display("FAIL clear_busy: busy cycles=%0d need 1024", bc); end
    tests++;
    if (dc != 1) begin fails++; $display("FAIL clear_done: done pulses=%0d need 1", dc); end
    tests++;
    if (ren_cnt != r0) begin fails++; $display("FAIL clear_start_ignored: reads=%0d need 0", ren_cnt - r0); end
    tests++;
    if (sbq.size() != 0) begin fails++; $display("FAIL clear_writes: %0d writes missing need 0", sbq.size()); end
  endtask

  task automatic test_single;
    int d0, n;
    d0 = done_cnt;
    start_frame(5);
    for (int i = 0; i < 5; i++) begin
      drive_ev(259, 1'b1);
      if (i == 0) begin
        tests++;
        if (ren !== 1'b1 || raddr !== AW'(259)) begin
          fails++;
          $display("FAIL single_read: ren=%b raddr=%0d need ren=1 raddr=259", ren, raddr);
        end
      end
      if (i == 1) begin
        tests++;
        if (wen !== 1'b0) begin fails++; $display("FAIL single_lat1: wen=%b need 0", wen); end
      end
      if (i == 2) begin
        tests++;
        if (wen !== 1'b1 || waddr !== AW'(259)) begin
          fails++;
          $display("FAIL single_lat2: wen=%b waddr=%0d need wen=1 waddr=259", wen, waddr);
        end
      end
    end
    ts_valid = 1'b0;
    wait_done(d0, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL single_done: done after %0d cycles need 2", n); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: busy=%b at done need 0", busy); end
    repeat (2) tick();
    tests++;
    if (mem[259] !== CW'(5)) begin fails++; $display("FAIL single_ram: RAM[259]=%0d need 5", mem[259]); end
  endtask

  task automatic test_hazard;
    int d0, n;
    int seq [6] = '{522, 200, 522, 522, 200, 522};
    d0 = done_cnt;
    start_frame(6);
    foreach (seq[i]) drive_ev(seq[i], 1'b1);
    ts_valid = 1'b0;
    wait_done(d0, n);
    repeat (2) tick();
    tests++;
    if (mem[522] !== CW'(4)) begin fails++; $display("FAIL hazard_a: RAM[522]=%0d need 4", mem[522]); end
    tests++;
    if (mem[200] !== CW'(2)) begin fails++; $display("FAIL hazard_b: RAM[200]=%0d need 2", mem[200]); end
  endtask

  task automatic test_saturate;
    int d0, n;
    pre_en = 1'b1;
    pre_addr = AW'(7);
    pre_data = CW'(MAXC - 1);
    tick();
    pre_en = 1'b0;
    model[7] = MAXC - 1;
    d0 = done_cnt;
    start_frame(3);
    repeat (3) drive_ev(7, 1'b1);
    ts_valid = 1'b0;
    wait_done(d0, n);
    repeat (2) tick();
    tests++;
    if (mem[7] !== CW'(MAXC)) begin fails++; $display("FAIL sat_ram: RAM[7]=%0d need %0d", mem[7], MAXC); end
    tests++;
    if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_flag: sat_flag=%b need 1", sat_flag); end
    repeat (3) tick();
    tests++;
    if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_sticky: sat_flag=%b need 1", sat_flag); end
    d0 = done_cnt;
    start_frame(1);
    tests++;
    if (sat_flag !== 1'b0) begin fails++; $display("FAIL sat_clear: sat_flag=%b need 0 after start", sat_flag); end
    drive_ev(300, 1'b1);
    ts_valid = 1'b0;
    wait_done(d0, n);
    repeat (2) tick();
  endtask

  task automatic test_drop;
    int d0, n, r0, w0;
    r0 = ren_cnt;
    w0 = wen_cnt;
    d0 = done_cnt;
    start_frame(2);
    for (int i = 0; i < 4; i++) drive_ev(100, i < 2);
    ts_valid = 1'b0;
    wait_done(d0, n);
    repeat (2) tick();
    tests++;
    if (ren_cnt - r0 != 2) begin fails++; $display("FAIL drop_reads: reads=%0d need 2", ren_cnt - r0); end
    tests++;
    if (wen_cnt - w0 != 2) begin fails++; $display("FAIL drop_writes: writes=%0d need 2", wen_cnt - w0); end
    tests++;
    if (mem[100] !== CW'(2)) begin fails++; $display("FAIL drop_ram: RAM[100]=%0d need 2", mem[100]); end
  endtask

  task automatic test_reset_mid;
    int d0, n;
    start_frame(10);
    repeat (2) drive_ev(259, 1'b0);
    ts_valid = 1'b0;
    res_n = 1'b0;
    #1;
    tests++;
    if ({raddr, ren, waddr, wdata, wen, busy, done, sat_flag} !== '0) begin
      fails++;
      $display("FAIL reset_mid: outputs=%h need 0", {raddr, ren, waddr, wdata, wen, busy, done, sat_flag});
    end
    tick();
    res_n = 1'b1;
    tick();
    d0 = done_cnt;
    start_frame(2);
    repeat (2) drive_ev(259, 1'b1);
    ts_valid = 1'b0;
    wait_done(d0, n);
    repeat (2) tick();
    tests++;
    if (mem[259] !== CW'(7)) begin fails++; $display("FAIL reset_restart: RAM[259]=%0d need 7", mem[259]); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single();
    test_hazard();
    test_saturate();
    test_drop();
    test_reset_mid();
    repeat (4) tick();
    tests++;
    if (sbq.size() != 0) begin fails++; $display("FAIL final_drain: %0d writes missing need 0", sbq.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
